// File: rtl/reg_bank_pkg.sv
// Shared op encodings, FSM state enum and width defaults for the register-bank controller.
package reg_bank_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_RD  = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WB,
    ST_RESP
  } state_e;

endpackage

// File: rtl/rb_alu.sv
// Combinational ALU for the register-bank controller; zero latency, no flow control.
// Shift amount is the low 5 bits of rd2; RD passes rd1 through.
module rb_alu
  import reg_bank_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  op_e           i_op,
  input  logic [DW-1:0] i_rd1,
  input  logic [DW-1:0] i_rd2,
  output logic [DW-1:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD: o_result = i_rd1 + i_rd2;
      OP_SUB: o_result = i_rd1 - i_rd2;
      OP_AND: o_result = i_rd1 & i_rd2;
      OP_OR:  o_result = i_rd1 | i_rd2;
      OP_XOR: o_result = i_rd1 ^ i_rd2;
      OP_SLL: o_result = i_rd1 << i_rd2[4:0];
      OP_SRL: o_result = i_rd1 >> i_rd2[4:0];
      OP_RD:  o_result = i_rd1;
    endcase
  end

endmodule

// File: rtl/reg_bank_ctrl.sv
// Single-command register-bank sequencer: read, execute, write back, respond; response 4 cycles after accept (3 for RD).
// cmd_ready only in IDLE; the response is held stable until rsp_ready.
module reg_bank_ctrl
  import reg_bank_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_src1,
  input  logic [AW-1:0] cmd_src2,
  output logic [AW-1:0] rb_a,
  output logic [AW-1:0] rb_b,
  input  logic [DW-1:0] rb_rd1,
  input  logic [DW-1:0] rb_rd2,
  output logic [AW-1:0] rb_c,
  output logic [DW-1:0] rb_load,
  output logic          rb_we,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_zero
);

  state_e        r_state;
  state_e        w_next;
  op_e           r_op;
  logic [AW-1:0] r_dst;
  logic [AW-1:0] r_a;
  logic [AW-1:0] r_b;
  logic [AW-1:0] r_c;
  logic [DW-1:0] r_load;
  logic [DW-1:0] r_result;
  logic [DW-1:0] w_alu;
  logic          w_accept;

  rb_alu #(.DW(DW)) u_alu (
    .i_op     (r_op),
    .i_rd1    (rb_rd1),
    .i_rd2    (rb_rd2),
    .o_result (w_alu)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Handshake outputs are masked during reset so nothing is accepted or written while rst is high.
  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rb_we     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid) w_next = ST_READ;
      end
      ST_READ: w_next = ST_EXEC;
      ST_EXEC: w_next = (r_op == OP_RD) ? ST_RESP : ST_WB;
      ST_WB: begin
        rb_we  = !rst;
        w_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = !rst;
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= OP_ADD;
      r_dst    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_load   <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= op_e'(cmd_op);
        r_dst <= cmd_dst;
        r_a   <= cmd_src1;
        r_b   <= cmd_src2;
      end
      if (r_state == ST_EXEC) begin
        r_result <= w_alu;
        if (r_op != OP_RD) begin
          r_c    <= r_dst;
          r_load <= w_alu;
        end
      end
    end
  end

  assign rb_a     = r_a;
  assign rb_b     = r_b;
  assign rb_c     = r_c;
  assign rb_load  = r_load;
  assign rsp_data = r_result;
  assign rsp_zero = (r_result == '0);

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Directed plus random bench for reg_bank_ctrl with an external bank and an architectural register model.
module tb_reg_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [2:0]  cmd_dst = '0;
  logic [2:0]  cmd_src1 = '0;
  logic [2:0]  cmd_src2 = '0;
  logic [2:0]  rb_a, rb_b, rb_c;
  logic [31:0] rb_rd1, rb_rd2, rb_load;
  logic        rb_we;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_zero;

  logic [31:0] bank [8];
  logic        pre_we = 1'b0;
  logic [2:0]  pre_addr = '0;
  logic [31:0] pre_dat = '0;

  logic [31:0] refr [8];
  int          we_cnt = 0;
  logic [2:0]  last_c = '0;
  logic [31:0] last_load = '0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  reg_bank_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dst   (cmd_dst),
    .cmd_src1  (cmd_src1),
    .cmd_src2  (cmd_src2),
    .rb_a      (rb_a),
    .rb_b      (rb_b),
    .rb_rd1    (rb_rd1),
    .rb_rd2    (rb_rd2),
    .rb_c      (rb_c),
    .rb_load   (rb_load),
    .rb_we     (rb_we),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero)
  );

  // Register bank with one-cycle registered read data.
  always @(posedge clk) begin
    if (pre_we) bank[pre_addr] <= pre_dat;
    else if (rb_we) bank[rb_c] <= rb_load;
    rb_rd1 <= bank[rb_a];
    rb_rd2 <= bank[rb_b];
  end

  always @(posedge clk) begin
    if (rb_we) begin
      we_cnt    <= we_cnt + 1;
      last_c    <= rb_c;
      last_load <= rb_load;
    end
  end

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << sh;
      3'd6:    return a >> sh;
      default: return a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] s1,
                        input logic [2:0] s2, input int hold);
    logic [31:0] exp;
    logic        is_rd;
    int          n;
    int          we0;
    exp   = model(op, refr[s1], refr[s2]);
    is_rd = (op == 3'd7);
    we0   = we_cnt;
    @(negedge clk);
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dst   = dst;
    cmd_src1  = s1;
    cmd_src2  = s2;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rb_a_read", {29'd0, rb_a}, {29'd0, s1});
    chk("rb_b_read", {29'd0, rb_b}, {29'd0, s2});
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, is_rd ? 32'd3 : 32'd4);
    chk("rsp_data", rsp_data, exp);
    chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, exp == 32'd0});
    chk("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 3'd0;
      cmd_dst   = 3'd0;
      @(negedge clk);
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_data", rsp_data, exp);
      chk("stall_ready", {31'd0, cmd_ready}, 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    chk("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
    chk("we_pulses", we_cnt - we0, is_rd ? 32'd0 : 32'd1);
    if (!is_rd) begin
      chk("wb_addr", {29'd0, last_c}, {29'd0, dst});
      chk("wb_data", last_load, exp);
      refr[dst] = exp;
    end
  endtask

  initial begin
    logic [31:0] pre [8];
    int          we0;
    pre[0] = 32'd0; pre[1] = 32'd7; pre[2] = 32'd1; pre[3] = 32'd14;
    pre[4] = 32'd0; pre[5] = 32'd0; pre[6] = 32'd0; pre[7] = 32'd0;

    // Preload the bank while the controller is held in reset.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pre_we   = 1'b1;
      pre_addr = 3'(i);
      pre_dat  = pre[i];
      refr[i]  = pre[i];
    end
    @(negedge clk);
    pre_we = 1'b0;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rb_we", {31'd0, rb_we}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_zero", {31'd0, rsp_zero}, 32'd1);
    chk("rst_rb_a", {29'd0, rb_a}, 32'd0);
    chk("rst_rb_b", {29'd0, rb_b}, 32'd0);
    chk("rst_rb_c", {29'd0, rb_c}, 32'd0);
    chk("rst_rb_load", rb_load, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    do_cmd(3'd0, 3'd4, 3'd1, 3'd2, 0);
    chk("add_r4", refr[4], 32'd8);
    do_cmd(3'd1, 3'd5, 3'd2, 3'd1, 0);
    chk("sub_r5", refr[5], 32'hFFFF_FFFA);
    do_cmd(3'd5, 3'd6, 3'd3, 3'd2, 0);
    chk("sll_r6", refr[6], 32'd28);
    do_cmd(3'd7, 3'd0, 3'd1, 3'd0, 0);
    do_cmd(3'd4, 3'd7, 3'd1, 3'd1, 0);
    chk("xor_r7", refr[7], 32'd0);
    do_cmd(3'd3, 3'd0, 3'd1, 3'd3, 3);

    // Reset while the command is in EXEC: it must never write back.
    we0 = we_cnt;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'd0;
    cmd_dst   = 3'd2;
    cmd_src1  = 3'd1;
    cmd_src2  = 3'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_we", {31'd0, rb_we}, 32'd0);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_idle", {31'd0, cmd_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("mid_rst_no_we", we_cnt - we0, 32'd0);
    chk("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    do_cmd(3'd0, 3'd4, 3'd1, 3'd2, 0);

    do_cmd(3'd0, 3'd1, 3'd1, 3'd2, 0);
    chk("b2b_first", refr[1], 32'd8);
    do_cmd(3'd0, 3'd1, 3'd1, 3'd2, 0);
    chk("b2b_second", refr[1], 32'd9);

    for (int k = 0; k < 40; k++) begin
      do_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bank_ctrl.md
REG_BANK_CTRL -- requirements
Module: reg_bank_ctrl

Interface
REQ-001 Parameter: DW, 32, data width of register-bank words and results.
REQ-002 Parameter: AW, 3, register address width (8 registers).
REQ-003 Clocking: one clock, clk; reset is synchronous and active-high, rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid&cmd_ready at a rising edge.
REQ-008 cmd_op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 RD (read only, no writeback).
REQ-009 cmd_dst, cmd_src1, cmd_src2  input  AW each  destination and source register indices.
REQ-010 rb_a, rb_b  output  AW  register-bank read addresses.
REQ-011 rb_rd1, rb_rd2  input  DW  register-bank read data, registered by the bank one cycle after the address.
REQ-012 rb_c  output  AW  register-bank write address.
REQ-013 rb_load  output  DW  register-bank write data.
REQ-014 rb_we  output  1  write strobe; the bank SHALL be written only in cycles where rb_we=1.
REQ-015 rsp_valid  output  1  result available.
REQ-016 rsp_ready  input  1  result consumed when rsp_valid&rsp_ready at a rising edge.
REQ-017 rsp_data  output  DW  result (written value, or rd1 for RD); rsp_zero  output  1  rsp_data==0.

Function
REQ-018 FSM states SHALL be IDLE, READ, EXEC, WB, RESP.
REQ-019 IDLE: cmd_ready=1; on accept, command fields SHALL be latched and the FSM SHALL go to READ.
REQ-020 READ: rb_a=src1, rb_b=src2 driven for exactly one cycle; next state EXEC.
REQ-021 EXEC: rb_rd1/rb_rd2 SHALL be sampled; result SHALL be registered; next state WB, or RESP when op=RD.
REQ-022 Arithmetic: ADD/SUB modulo 2^DW, carries discarded; SLL/SRL shift rd1 by rd2[4:0], zero fill; RD result = rd1.
REQ-023 WB: rb_c=dst, rb_load=result, rb_we=1 for exactly one cycle; next state RESP.
REQ-024 RESP: rsp_valid=1 with rsp_data/rsp_zero stable until rsp_ready=1; on handshake return to IDLE.
REQ-025 Latency: rsp_valid SHALL rise 4 cycles after command accept (3 for RD).
REQ-026 cmd_ready SHALL be 0 in every state except IDLE; one command in flight at most.
REQ-027 rsp_ready asserted outside RESP SHALL have no effect.
REQ-028 src1, src2, dst may be equal; dst=src SHALL read the old value and write the new one.
REQ-029 A command issued after a response SHALL observe the previous writeback (no stale read).
REQ-030 rb_a, rb_b, rb_c, rb_load SHALL hold their last value when not in use; rb_we=0 outside WB.

Reset
REQ-031 rst=1 at a rising edge SHALL force IDLE from any state, including mid-operation; the pending command SHALL be discarded.
REQ-032 Reset values: cmd_ready=0 during reset then 1, rsp_valid=0, rb_we=0, rsp_data=0, rsp_zero=1, rb_a=rb_b=rb_c=0, rb_load=0.
REQ-033 Reset asserted in EXEC or READ SHALL guarantee no rb_we pulse for that command.

Structure
REQ-034 Shared package reg_bank_pkg SHALL hold op encodings, the FSM state enum and the DW/AW defaults.
REQ-035 One combinational sub-module rb_alu (op, rd1, rd2 -> result) SHALL implement REQ-022; the FSM stays in reg_bank_ctrl.

Verification
REQ-036 Bank preloaded r1=7, r2=1, r3=14: ADD dst=4 src1=1 src2=2 -> one rb_we with rb_c=4, rb_load=8; rsp_data=8 at accept+4.
REQ-037 SUB dst=5 src1=2 src2=1 -> rb_load=rsp_data=0xFFFFFFFA; SLL dst=6 src1=3 src2=2 -> 28.
REQ-038 RD src1=1 -> rsp_data=7 at accept+3, rb_we never asserted, rsp_zero=0; XOR r1,r1 -> 0, rsp_zero=1.
REQ-039 rsp_ready held low 3 cycles in RESP -> rsp_valid, rsp_data stable, cmd_ready=0, new cmd_valid ignored.
REQ-040 rst pulsed during EXEC of ADD -> no rb_we, rsp_valid=0, IDLE next cycle; following ADD completes normally.
REQ-041 Back-to-back: ADD dst=1 src=1,2 then ADD dst=1 src=1,2 -> responses 8 then 9.
